// File: rtl/hc194_pkg.sv
// hc194 shared constants: S-pin mode codes, sequencer states, transmit direction codes.
// Pure declarations, no logic and no handshake.
package hc194_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SR   = 2'b01;
    localparam logic [1:0] MODE_SL   = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_DONE   = 2'd2,
        ST_PARITY = 2'd3
    } state_t;

    localparam logic DIR_LSB_FIRST = 1'b0;
    localparam logic DIR_MSB_FIRST = 1'b1;

endpackage

// File: rtl/hc194_core.sv
// HC194 universal shift register (hold / shift right / shift left / load) with async active-low clear.
// One-cycle latency: Q updates on the rising edge; there is no backpressure.
module hc194_core
    import hc194_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             Clk,
    input  logic             R,
    input  logic [1:0]       mode,
    input  logic             DSR,
    input  logic             DSL,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge Clk or negedge R) begin
        if (!R) begin
            r_q <= '0;
        end else begin
            case (mode)
                MODE_SR:   r_q <= {DSR, r_q[WIDTH-1:1]};
                MODE_SL:   r_q <= {r_q[WIDTH-2:0], DSL};
                MODE_LOAD: r_q <= D;
                default:   r_q <= r_q;
            endcase
        end
    end

    assign Q = r_q;

endmodule

// File: rtl/hc194_ser_tx.sv
// HC194 shift register plus serial transmit sequencer: bit 0 of the frame appears one cycle after Start, Done follows the last bit.
// No backpressure; Start is honoured only in IDLE. Define HC194_SER_TX_PARITY_EN to append an even-parity bit.
module hc194_ser_tx
    import hc194_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             Clk,
    input  logic             R,
    input  logic [1:0]       S,
    input  logic             DSR,
    input  logic             DSL,
    input  logic [WIDTH-1:0] D,
    input  logic             Start,
    input  logic             Dir,
    output logic [WIDTH-1:0] Q,
    output logic             Ser_Out,
    output logic             Ser_Valid,
    output logic             Busy,
    output logic             Done
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dir;
    logic [1:0]       w_mode;
    logic [WIDTH-1:0] w_q;
`ifdef HC194_SER_TX_PARITY_EN
    logic             r_parity;
`endif

    // The sequencer owns the core's mode pins whenever it is not idle.
    always_comb begin
        w_mode = MODE_HOLD;
        case (r_state)
            ST_IDLE:  w_mode = Start ? MODE_LOAD : S;
            ST_SHIFT: w_mode = (r_dir == DIR_MSB_FIRST) ? MODE_SL : MODE_SR;
            default:  w_mode = MODE_HOLD;
        endcase
    end

    hc194_core #(.WIDTH(WIDTH)) u_core (
        .Clk  (Clk),
        .R    (R),
        .mode (w_mode),
        .DSR  (DSR),
        .DSL  (DSL),
        .D    (D),
        .Q    (w_q)
    );

    always_ff @(posedge Clk or negedge R) begin
        if (!R) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_dir    <= DIR_LSB_FIRST;
`ifdef HC194_SER_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (Start) begin
                        r_state  <= ST_SHIFT;
                        r_cnt    <= '0;
                        r_dir    <= Dir;
`ifdef HC194_SER_TX_PARITY_EN
                        r_parity <= ^D;
`endif
                    end
                end
                ST_SHIFT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
`ifdef HC194_SER_TX_PARITY_EN
                        r_state <= ST_PARITY;
`else
                        r_state <= ST_DONE;
`endif
                    end
                end
`ifdef HC194_SER_TX_PARITY_EN
                ST_PARITY: r_state <= ST_DONE;
`endif
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        Ser_Out = 1'b0;
        case (r_state)
            ST_SHIFT:  Ser_Out = (r_dir == DIR_MSB_FIRST) ? w_q[WIDTH-1] : w_q[0];
`ifdef HC194_SER_TX_PARITY_EN
            ST_PARITY: Ser_Out = r_parity;
`endif
            default:   Ser_Out = 1'b0;
        endcase
    end

    assign Q         = w_q;
    assign Busy      = (r_state == ST_SHIFT) || (r_state == ST_PARITY);
    assign Ser_Valid = Busy;
    assign Done      = (r_state == ST_DONE);

endmodule

// File: tb/tb_hc194_ser_tx.sv
// Bench for hc194_ser_tx: directed cases and random traffic against a frame-level reference model.
// Honours HC194_SER_TX_PARITY_EN in the same way as the RTL.
module tb_hc194_ser_tx;

    localparam int W = 4;

    logic         Clk = 1'b0;
    logic         R   = 1'b0;
    logic [1:0]   S     = 2'b00;
    logic         DSR   = 1'b0;
    logic         DSL   = 1'b0;
    logic [W-1:0] D     = '0;
    logic         Start = 1'b0;
    logic         Dir   = 1'b0;
    logic [W-1:0] Q;
    logic         Ser_Out, Ser_Valid, Busy, Done;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: register value plus the list of serial bits still to be sent.
    int unsigned m_q    = 0;
    bit          m_bits[$];
    int          m_shl  = 0;
    bit          m_dir  = 0;
    bit          m_done = 0;

    hc194_ser_tx #(.WIDTH(W)) dut (
        .Clk       (Clk),
        .R         (R),
        .S         (S),
        .DSR       (DSR),
        .DSL       (DSL),
        .D         (D),
        .Start     (Start),
        .Dir       (Dir),
        .Q         (Q),
        .Ser_Out   (Ser_Out),
        .Ser_Valid (Ser_Valid),
        .Busy      (Busy),
        .Done      (Done)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q = 0;
        m_bits.delete();
        m_shl = 0;
        m_dir = 0;
        m_done = 0;
    endtask

    task automatic model_edge();
        int unsigned mask;
        mask = (32'd1 << W) - 1;
        if (m_done) begin
            m_done = 0;
        end else if (m_bits.size() > 0) begin
            void'(m_bits.pop_front());
            if (m_shl > 0) begin
                if (!m_dir) m_q = (m_q >> 1) | (32'(DSR) << (W - 1));
                else        m_q = ((m_q << 1) | 32'(DSL)) & mask;
                m_shl--;
            end
            if (m_bits.size() == 0) m_done = 1;
        end else if (Start) begin
            m_q = 32'(D);
            m_dir = Dir;
            m_shl = W;
            m_bits.delete();
            for (int i = 0; i < W; i++) m_bits.push_back(Dir ? D[W-1-i] : D[i]);
`ifdef HC194_SER_TX_PARITY_EN
            m_bits.push_back(^D);
`endif
        end else begin
            case (S)
                2'b01:   m_q = (m_q >> 1) | (32'(DSR) << (W - 1));
                2'b10:   m_q = ((m_q << 1) | 32'(DSL)) & mask;
                2'b11:   m_q = 32'(D);
                default: m_q = m_q;
            endcase
        end
    endtask

    task automatic check_outs();
        bit act;
        act = (m_bits.size() > 0);
        chk("q", 32'(Q), m_q);
        chk("ser_valid", 32'(Ser_Valid), 32'(act));
        chk("busy", 32'(Busy), 32'(act));
        chk("done", 32'(Done), 32'(m_done));
        chk("ser_out", 32'(Ser_Out), act ? 32'(m_bits[0]) : 32'd0);
    endtask

    // Inputs are set #1 after an edge; model and DUT both consume them at the next edge.
    task automatic cycle();
        @(posedge Clk);
        model_edge();
        #1;
        check_outs();
    endtask

    initial begin
        bit exp_lsb[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        bit exp_msb[4] = '{1'b1, 1'b0, 1'b1, 1'b1};

        #12;
        chk("rst_q", 32'(Q), 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_valid", 32'(Ser_Valid), 32'd0);
        chk("rst_ser_out", 32'(Ser_Out), 32'd0);
        @(negedge Clk);
        R = 1'b1;
        model_reset();
        cycle();

        // Manual IDLE modes
        S = 2'b11; D = 4'b0110; cycle(); chk("man_load", 32'(Q), 32'h6);
        S = 2'b01; DSR = 1'b1;  cycle(); chk("man_sr", 32'(Q), 32'hB);
        S = 2'b10; DSL = 1'b0;  cycle(); chk("man_sl", 32'(Q), 32'h6);
        S = 2'b00; D = 4'b1111; cycle(); chk("man_hold", 32'(Q), 32'h6);

        // LSB-first frame of 1011, S=11 alongside Start must still transmit
        S = 2'b11; D = 4'b1011; Dir = 1'b0; Start = 1'b1;
        cycle();
        Start = 1'b0; D = 4'b0000;
        for (int i = 0; i < W; i++) begin
            chk("lsb_bit", 32'(Ser_Out), 32'(exp_lsb[i]));
            chk("lsb_busy", 32'(Busy), 32'd1);
            chk("lsb_done_low", 32'(Done), 32'd0);
            cycle();
        end
`ifdef HC194_SER_TX_PARITY_EN
        chk("lsb_parity", 32'(Ser_Out), 32'd1);
        chk("lsb_parity_valid", 32'(Ser_Valid), 32'd1);
        cycle();
`endif
        chk("lsb_done", 32'(Done), 32'd1);
        chk("lsb_done_busy", 32'(Busy), 32'd0);
        cycle();
        chk("lsb_done_once", 32'(Done), 32'd0);

        // MSB-first frame with Dir toggling mid-frame
        S = 2'b00; D = 4'b1011; Dir = 1'b1; Start = 1'b1;
        cycle();
        Start = 1'b0;
        for (int i = 0; i < W; i++) begin
            chk("msb_bit", 32'(Ser_Out), 32'(exp_msb[i]));
            Dir = ~Dir;
            cycle();
        end
`ifdef HC194_SER_TX_PARITY_EN
        cycle();
`endif
        chk("msb_done", 32'(Done), 32'd1);
        cycle();

        // Start held high: frames restart only from IDLE
        Start = 1'b1;
        for (int i = 0; i < 3 * (W + 3); i++) begin
            D = 4'($urandom);
            Dir = 1'($urandom);
            cycle();
        end
        Start = 1'b0;
        for (int i = 0; i < W + 3; i++) cycle();

        // Asynchronous reset in the middle of a frame
        D = 4'b1101; Dir = 1'b0; Start = 1'b1;
        cycle();
        Start = 1'b0;
        cycle();
        #2;
        R = 1'b0;
        #1;
        chk("midrst_q", 32'(Q), 32'd0);
        chk("midrst_busy", 32'(Busy), 32'd0);
        chk("midrst_valid", 32'(Ser_Valid), 32'd0);
        chk("midrst_done", 32'(Done), 32'd0);
        model_reset();
        @(negedge Clk);
        R = 1'b1;
        cycle();
        chk("midrst_no_done", 32'(Done), 32'd0);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            Start = ($urandom_range(0, 4) == 0);
            S     = 2'($urandom);
            D     = 4'($urandom);
            DSR   = 1'($urandom);
            DSL   = 1'($urandom);
            Dir   = 1'($urandom);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hc194_ser_tx.md
Name: hc194_ser_tx

Overview:
- 74HC194-flavoured universal shift register with an on-chip serial transmit sequencer.
- Idle: behaves as a bidirectional universal shift register under mode pins S.
- Start: captures parallel word D, then shifts it out one bit per clock, LSB-first or MSB-first, with Busy/Done handshake.
- Serves as the transmit end for serial links built from the JK/flip-flop parts in this library.

Parameters:
- WIDTH, 4, data word and shift register width, range 2..16.

Ports:
- Clk  in  1  clock; all state changes on rising edge.
- R  in  1  asynchronous active-low reset; clears everything immediately.
- S  in  2  manual mode in IDLE: 00 hold, 01 shift right (toward bit 0), 10 shift left (toward MSB), 11 parallel load.
- DSR  in  1  serial fill entering Q[WIDTH-1] on right shift.
- DSL  in  1  serial fill entering Q[0] on left shift.
- D  in  WIDTH  parallel data.
- Start  in  1  transmit request, level-sampled.
- Dir  in  1  sampled with Start: 0 LSB-first (right shift), 1 MSB-first (left shift).
- Q  out  WIDTH  register contents.
- Ser_Out  out  1  serial data bit.
- Ser_Valid  out  1  Ser_Out holds a valid data or parity bit.
- Busy  out  1  transmission in progress.
- Done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (R=0, asynchronous):
  - Q=0, state IDLE, bit count 0, latched Dir 0.
  - Ser_Out=0, Ser_Valid=0, Busy=0, Done=0.
  - Release is synchronous to the next rising edge.
- States: IDLE, SHIFT, DONE; PARITY is added when the optional feature is compiled in.
- IDLE:
  - Start=1: Q<=D, latch Dir, count<=0, go to SHIFT. Start has priority over S.
  - Start=0: apply S per the HC194 truth table.
    - Right shift: Q<={DSR,Q[WIDTH-1:1]}.
    - Left shift: Q<={Q[WIDTH-2:0],DSL}.
  - Outputs: Busy=0, Ser_Valid=0, Ser_Out=0.
- SHIFT:
  - Busy=1, Ser_Valid=1.
  - Ser_Out=Q[0] if latched Dir=0, Q[WIDTH-1] if Dir=1. Driven combinationally from Q.
  - Each edge: shift in the latched direction with DSR/DSL fill, count<=count+1.
  - When count==WIDTH-1 at the edge: go to DONE, or PARITY if enabled.
  - Exactly WIDTH data bits, one per cycle.
  - Counter width $clog2(WIDTH+1); it never wraps.
- DONE:
  - Done=1, Busy=0, Ser_Valid=0 for exactly one cycle, then IDLE.
  - Start in DONE is ignored; a new frame needs Start in IDLE.
  - Minimum spacing: WIDTH+2 cycles Start-to-Start.
- Start, S and D are ignored outside IDLE. Dir changes mid-frame have no effect.
- Latency: Start sampled at edge k → bit 0 valid in cycle k+1 → last data bit in cycle k+WIDTH → Done in cycle k+WIDTH+1 (no parity).
- Reset asserted mid-frame aborts immediately: no Done pulse, Q=0.
- Post-frame Q: contents reflect the fills shifted in; not restored.

Optional Feature:
- Macro: HC194_SER_TX_PARITY_EN.
- Defined:
  - At Start, also register the even parity ^D.
  - After the last data bit, enter PARITY for one cycle: Ser_Out=parity, Ser_Valid=1, Busy=1, Q holds.
  - Then DONE; frame is WIDTH+1 bits.
- Undefined: no PARITY state and no parity register; SHIFT goes directly to DONE.

Decomposition:
- Package hc194_pkg:
  - Mode constants MODE_HOLD=2'b00, MODE_SR=2'b01, MODE_SL=2'b10, MODE_LOAD=2'b11.
  - State enum type (IDLE, SHIFT, DONE, PARITY).
  - DIR_LSB_FIRST=0, DIR_MSB_FIRST=1.
- Sub-module hc194_core:
  - Pure parameterised universal shift register: Clk, R, mode, DSR, DSL, D, Q.
  - The sequencer overrides mode: LOAD at Start; SR or SL during SHIFT; HOLD in DONE/PARITY.

Test Plan:
- Reset mid-frame: R pulsed low at a time not aligned to Clk → Q=0, Busy=0, no Done, Ser_Valid=0 immediately; next Start works normally.
- WIDTH=4, D=4'b1011, Dir=0, Start one cycle → Ser_Out 1,1,0,1 in cycles k+1..k+4 with Ser_Valid=1, Busy=1; Done=1 in k+5 only.
- Same D, Dir=1 → Ser_Out 1,0,1,1; Dir toggled during frame → sequence unchanged.
- Manual IDLE mode:
  - S=11, D=4'b0110 → Q=0110.
  - S=01, DSR=1 → Q=1011.
  - S=10, DSL=0 → Q=0110.
  - S=00 → Q holds.
- Start held high continuously → frames start only from IDLE (period WIDTH+2 = 6 cycles); S=11 with Start=1 → transmit, not plain load.
- With HC194_SER_TX_PARITY_EN, D=4'b1011 Dir=0 → Ser_Out 1,1,0,1, then parity 1 in cycle k+5; Done in k+6.
